// File: rtl/wb_reg_ctrl.sv
// Write-back controller: captures an execute result, performs the data read for loads,
// and writes the integer register file. Optional macro WB_LOAD_ALIGN_EN selects in-dword load alignment.
module wb_reg_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_finish,
  input  logic            pipe2_valid,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] ram_addr,
  input  logic [4:0]      rd,
  input  logic            rf_wen_req,
  input  logic            is_load,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  output logic            mem_ren,
  output logic [XLEN-1:0] mem_raddr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            wb_reg_finish,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MEM   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic            wen_req_q, wen_req_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            mem_ren_q, mem_ren_d;
  logic [XLEN-1:0] mem_raddr_q, mem_raddr_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            finish_q, finish_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] ld_raw;

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                  input logic [1:0] size,
                                                  input logic uns);
    logic [XLEN-1:0] r;
    r = '0;
    case (size)
      2'b00:   r = {{(XLEN-8){~uns & raw[7]}}, raw[7:0]};
      2'b01:   r = {{(XLEN-16){~uns & raw[15]}}, raw[15:0]};
      2'b10:   r = {{(XLEN-32){~uns & raw[31]}}, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

`ifdef WB_LOAD_ALIGN_EN
  // Bring the addressed byte lane down to bit 0 before extension.
  assign ld_raw = mem_rdata >> {mem_raddr_q[2:0], 3'b000};
`else
  assign ld_raw = mem_rdata;
`endif

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wen_req_d   = wen_req_q;
    size_d      = size_q;
    uns_d       = uns_q;
    mem_raddr_d = mem_raddr_q;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    mem_ren_d   = 1'b0;
    rf_wen_d    = 1'b0;
    finish_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (alu_finish && pipe2_valid) begin
          rd_d      = rd;
          wen_req_d = rf_wen_req;
          size_d    = ld_size;
          uns_d     = ld_unsigned;
          if (is_load) begin
            state_d     = ST_MEM;
            mem_ren_d   = 1'b1;
            mem_raddr_d = ram_addr;
          end else begin
            // Outputs are registered, so WRITE-cycle values are loaded on entry.
            state_d    = ST_WRITE;
            rf_wen_d   = rf_wen_req && (rd != 5'd0);
            rf_waddr_d = rd;
            rf_wdata_d = alu_result;
            finish_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM: begin
        if (mem_rvalid) begin
          state_d    = ST_WRITE;
          rf_wen_d   = wen_req_q && (rd_q != 5'd0);
          rf_waddr_d = rd_q;
          rf_wdata_d = load_extend(ld_raw, size_q, uns_q);
          finish_d   = 1'b1;
        end else begin
          mem_ren_d = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_q        <= 5'd0;
      wen_req_q   <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_raddr_q <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= '0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wen_req_q   <= wen_req_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      mem_ren_q   <= mem_ren_d;
      mem_raddr_q <= mem_raddr_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      finish_q    <= finish_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_ren       = mem_ren_q;
  assign mem_raddr     = mem_raddr_q;
  assign rf_wen        = rf_wen_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign wb_reg_finish = finish_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_wb_reg_ctrl.sv
// Scoreboard bench for wb_reg_ctrl: the driver pushes expected writes, a negedge monitor
// pops and compares them whenever wb_reg_finish is seen.
module tb_wb_reg_ctrl;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic alu_finish = 1'b0, pipe2_valid = 1'b0;
  logic [XLEN-1:0] alu_result = '0, ram_addr = '0, mem_rdata = '0;
  logic [4:0] rd = 5'd0;
  logic rf_wen_req = 1'b0, is_load = 1'b0, ld_unsigned = 1'b0, mem_rvalid = 1'b0;
  logic [1:0] ld_size = 2'd0;
  logic mem_ren, rf_wen, wb_reg_finish, busy;
  logic [XLEN-1:0] mem_raddr, rf_wdata;
  logic [4:0] rf_waddr;

  wb_reg_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .alu_finish(alu_finish), .pipe2_valid(pipe2_valid),
    .alu_result(alu_result), .ram_addr(ram_addr), .rd(rd), .rf_wen_req(rf_wen_req),
    .is_load(is_load), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_reg_finish(wb_reg_finish), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } exp_t;

  exp_t q[$];
  exp_t got;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [4:0]  last_waddr = 5'd0;
  logic [63:0] last_wdata = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load: pick bytes from the doubleword, then sign/zero extend.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [63:0] addr,
                                           input logic [1:0] size, input logic uns);
    int n;
    int off;
    logic [63:0] v;
    n = 1 << size;
`ifdef WB_LOAD_ALIGN_EN
    off = int'(addr[2:0]);
`else
    off = 0;
`endif
    v = 64'd0;
    for (int b = 0; b < n; b++)
      if (off + b < 8) v[8*b +: 8] = rdata[8*(off+b) +: 8];
    if (!uns && v[8*n-1])
      for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
    return v;
  endfunction

  // Monitor: every completion must match the oldest expectation; outside WRITE the write port holds.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (wb_reg_finish) begin
        if (q.size() == 0) begin
          chk("unexpected_finish", {63'd0, wb_reg_finish}, 64'd0);
        end else begin
          got = q.pop_front();
          chk("finish_cycle", 64'(cyc), 64'(got.cyc));
          chk("rf_wen", {63'd0, rf_wen}, {63'd0, got.wen});
          chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, got.waddr});
          chk("rf_wdata", rf_wdata, got.wdata);
          last_waddr = got.waddr;
          last_wdata = got.wdata;
        end
      end else begin
        chk("wen_without_finish", {63'd0, rf_wen}, 64'd0);
        chk("waddr_hold", {59'd0, rf_waddr}, {59'd0, last_waddr});
        chk("wdata_hold", rf_wdata, last_wdata);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic scramble();
    rd          = 5'($urandom);
    alu_result  = {$urandom, $urandom};
    ram_addr    = {$urandom, $urandom};
    rf_wen_req  = 1'($urandom);
    is_load     = 1'($urandom);
    ld_size     = 2'($urandom);
    ld_unsigned = 1'($urandom);
  endtask

  task automatic issue(input logic ld, input logic [1:0] sz, input logic uns, input logic [4:0] rdi,
                       input logic wreq, input logic [63:0] res, input logic [63:0] addr,
                       input logic [63:0] rdata, input int d, input bit spurious);
    exp_t e;
    int c;
    wait_idle();
    alu_finish = 1'b1; pipe2_valid = 1'b1; is_load = ld; ld_size = sz; ld_unsigned = uns;
    rd = rdi; rf_wen_req = wreq; alu_result = res; ram_addr = addr;
    @(posedge clk);
    #1;
    c = cyc;
    e.wen   = wreq && (rdi != 5'd0);
    e.waddr = rdi;
    e.wdata = ld ? ref_load(rdata, addr, sz, uns) : res;
    e.cyc   = ld ? c + d + 1 : c;
    q.push_back(e);
    @(negedge clk);
    alu_finish = 1'b0;
    scramble();
    if (ld) begin
      repeat (d) begin
        chk("mem_ren_in_mem", {63'd0, mem_ren}, 64'd1);
        chk("mem_raddr", mem_raddr, addr);
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom};
        alu_finish = spurious;
        @(negedge clk);
      end
      chk("mem_ren_in_mem", {63'd0, mem_ren}, 64'd1);
      chk("mem_raddr", mem_raddr, addr);
      alu_finish = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
    end
    chk("mem_ren_in_write", {63'd0, mem_ren}, 64'd0);
    alu_finish = 1'b0;
  endtask

  initial begin : timeout
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [1:0]  sz;
    logic [63:0] a;
    #1 rst = 1'b1;
    #1;
    chk("rst_mem_ren", {63'd0, mem_ren}, 64'd0);
    chk("rst_mem_raddr", mem_raddr, 64'd0);
    chk("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    chk("rst_finish", {63'd0, wb_reg_finish}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    issue(1'b0, 2'd0, 1'b0, 5'd5, 1'b1, 64'h1234, 64'd0, 64'd0, 0, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 64'hDEAD_BEEF, 64'd0, 64'd0, 0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 5'd7, 1'b1, 64'd0, 64'h8000_0003, 64'h0000_0000_8000_0000, 3, 1'b1);
    issue(1'b1, 2'd0, 1'b1, 5'd8, 1'b1, 64'd0, 64'h8000_0003, 64'h0000_0000_8000_0000, 3, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 5'd9, 1'b1, 64'd0, 64'h1000, 64'hFEDC_BA98_7654_3210, 0, 1'b0);

    // alu_finish without pipe2_valid must do nothing.
    wait_idle();
    scramble();
    alu_finish = 1'b1; pipe2_valid = 1'b0;
    @(negedge clk);
    alu_finish = 1'b0;
    chk("no_issue_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("no_issue_busy2", {63'd0, busy}, 64'd0);

    // Reset while waiting for memory, then a stale mem_rvalid.
    wait_idle();
    alu_finish = 1'b1; pipe2_valid = 1'b1; is_load = 1'b1; rd = 5'd3; rf_wen_req = 1'b1;
    ram_addr = 64'h2000; ld_size = 2'd3;
    @(negedge clk);
    alu_finish = 1'b0;
    chk("pre_rst_mem_ren", {63'd0, mem_ren}, 64'd1);
    #2 rst = 1'b1;
    last_waddr = 5'd0;
    last_wdata = 64'd0;
    #1;
    chk("mid_rst_mem_ren", {63'd0, mem_ren}, 64'd0);
    chk("mid_rst_mem_raddr", mem_raddr, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_rf_wdata", rf_wdata, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h1111_2222_3333_4444;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
      chk("post_rst_rf_wen", {63'd0, rf_wen}, 64'd0);
    end
    mem_rvalid = 1'b0;

    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom);
      a  = {$urandom, $urandom};
      a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      issue(1'($urandom), sz, 1'($urandom), 5'($urandom), 1'($urandom), {$urandom, $urandom}, a,
            {$urandom, $urandom}, int'($urandom_range(0, 4)), 1'($urandom));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
